mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of each lane data word and of data_out.
REQ-002 Parameter: MAX_BURST, 4, maximum consecutive grants to one lane while both lanes are pending; legal range 1..15.
REQ-003 Port: clk_2f  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_L  input  1  synchronous, active-low reset.
REQ-005 Port: fifo_empty_0  input  1  lane-0 upstream FIFO empty flag.
REQ-006 Port: fifo_data_0  input  DATA_W  lane-0 FIFO head word (show-ahead), valid whenever fifo_empty_0=0.
REQ-007 Port: fifo_empty_1  input  1  lane-1 upstream FIFO empty flag.
REQ-008 Port: fifo_data_1  input  DATA_W  lane-1 FIFO head word (show-ahead), valid whenever fifo_empty_1=0.
REQ-009 Port: out_almost_full  input  1  downstream backpressure; 1 forbids any pop.
REQ-010 Port: pop_0  output  1  lane-0 pop strobe, combinational.
REQ-011 Port: pop_1  output  1  lane-1 pop strobe, combinational.
REQ-012 Port: data_out  output  DATA_W  registered granted word.
REQ-013 Port: valid_out  output  1  registered qualifier for data_out.
REQ-014 Port: state  output  2  FSM state: RESET=00, INIT=01, IDLE=10, ACTIVE=11.

Function
REQ-015 Grant-eligible cycle: state is IDLE or ACTIVE, reset_L=1, out_almost_full=0, and at least one fifo_empty_x=0.
REQ-016 Outside a grant-eligible cycle, pop_0 and pop_1 SHALL both be 0.
REQ-017 At most one pop_x is 1 in any cycle.
REQ-018 Exactly one lane non-empty: pop that lane.
REQ-019 Both lanes non-empty: if burst_cnt < MAX_BURST, pop last_lane; otherwise pop the other lane.
REQ-020 On pop of lane L: if L == last_lane, burst_cnt increments, saturating at MAX_BURST; otherwise last_lane <= L and burst_cnt <= 1.
REQ-021 Cycles without a pop SHALL leave last_lane and burst_cnt unchanged, including backpressure stalls.
REQ-022 Latency: pop_x=1 in cycle n gives data_out = fifo_data_x sampled at n, with valid_out=1, in cycle n+1.
REQ-023 A cycle with no pop gives valid_out=0 in the next cycle; data_out holds its previous value.
REQ-024 FSM transitions: RESET when reset_L=0; RESET->INIT on the first cycle with reset_L=1; INIT->IDLE unconditionally after one cycle, with no pops in INIT; IDLE/ACTIVE->ACTIVE if a pop occurs this cycle, else ->IDLE.
REQ-025 burst_cnt width SHALL be 4 bits; MAX_BURST=1 yields strict alternation under contention.
REQ-026 Neither lane SHALL wait more than MAX_BURST grant cycles while pending under contention.

Reset
REQ-027 When reset_L is sampled 0: state=RESET, data_out=0, valid_out=0, last_lane=1, burst_cnt=MAX_BURST.
REQ-028 pop_0/pop_1 SHALL be 0 combinationally whenever reset_L=0, including reset asserted mid-burst.
REQ-029 Due to the reset values, the first contested grant after reset goes to lane 0.

Verification
REQ-030 Hold reset_L=0 for 3 cycles with both FIFOs non-empty -> pops 0, valid_out=0, data_out=0x00, state=00; release -> state 01 for one cycle, then 10/11; first pop occurs in the cycle after INIT.
REQ-031 Only lane 1 non-empty, head 0xA5, no backpressure -> pop_1=1 in cycle n; data_out=0xA5, valid_out=1 in cycle n+1; state=ACTIVE.
REQ-032 Both lanes continuously non-empty, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,...; every valid_out=1.
REQ-033 Both lanes contended, out_almost_full=1 for 3 cycles after the second lane-0 grant -> no pops and valid_out=0 during the stall; then lane 0 receives exactly 2 more grants before lane 1.
REQ-034 reset_L=0 for 1 cycle during a lane-1 burst -> pops 0 in that cycle, INIT follows, and the first contested grant goes to lane 0.
REQ-035 Lane 0 empties mid-burst while lane 1 is pending -> lane 1 is granted the next cycle and burst_cnt=1.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-lane FIFO-draining arbiter with bounded bursts under contention.
// Pops are combinational toward the FIFOs; the granted word is registered.
module mux_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic              fifo_empty_0,
    input  logic [DATA_W-1:0] fifo_data_0,
    input  logic              fifo_empty_1,
    input  logic [DATA_W-1:0] fifo_data_1,
    input  logic              out_almost_full,
    output logic              pop_0,
    output logic              pop_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t            state_r;
    logic [DATA_W-1:0] data_out_r;
    logic              valid_r;
    logic              last_lane_r;
    logic [3:0]        burst_cnt_r;

    logic eligible_s;
    logic grant_s;
    logic pop_0_s;
    logic pop_1_s;
    logic pop_any_s;

    // Grant decision: stay on the last lane until its burst saturates, then switch.
    always_comb begin
        pop_0_s    = 1'b0;
        pop_1_s    = 1'b0;
        grant_s    = 1'b0;
        eligible_s = reset_L && !out_almost_full
                     && ((state_r == ST_IDLE) || (state_r == ST_ACTIVE))
                     && (!fifo_empty_0 || !fifo_empty_1);
        if (eligible_s) begin
            if (!fifo_empty_0 && !fifo_empty_1) begin
                if (burst_cnt_r < MAX_CNT) begin
                    grant_s = last_lane_r;
                end else begin
                    grant_s = ~last_lane_r;
                end
            end else if (!fifo_empty_0) begin
                grant_s = 1'b0;
            end else begin
                grant_s = 1'b1;
            end
            pop_0_s = ~grant_s;
            pop_1_s = grant_s;
        end else begin
            pop_0_s = 1'b0;
            pop_1_s = 1'b0;
        end
        pop_any_s = pop_0_s | pop_1_s;
    end

    // FSM, burst bookkeeping and registered output word.
    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            state_r     <= ST_RESET;
            data_out_r  <= '0;
            valid_r     <= 1'b0;
            last_lane_r <= 1'b1;
            burst_cnt_r <= MAX_CNT;
        end else begin
            valid_r <= pop_any_s;
            if (pop_any_s) begin
                data_out_r <= grant_s ? fifo_data_1 : fifo_data_0;
                if (grant_s == last_lane_r) begin
                    if (burst_cnt_r < MAX_CNT) begin
                        burst_cnt_r <= burst_cnt_r + 4'd1;
                    end else begin
                        burst_cnt_r <= burst_cnt_r;
                    end
                end else begin
                    last_lane_r <= grant_s;
                    burst_cnt_r <= 4'd1;
                end
            end else begin
                data_out_r <= data_out_r;
            end
            case (state_r)
                ST_RESET:  state_r <= ST_INIT;
                ST_INIT:   state_r <= ST_IDLE;
                ST_IDLE,
                ST_ACTIVE: state_r <= pop_any_s ? ST_ACTIVE : ST_IDLE;
                default:   state_r <= ST_RESET;
            endcase
        end
    end

    assign pop_0     = pop_0_s;
    assign pop_1     = pop_1_s;
    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign state     = state_r;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed vector table for mux_arbiter plus a contested-burst sequence.
module tb_mux_arbiter;

    logic       clk_2f = 1'b0;
    logic       reset_L;
    logic       fifo_empty_0;
    logic [7:0] fifo_data_0;
    logic       fifo_empty_1;
    logic [7:0] fifo_data_1;
    logic       out_almost_full;
    logic       pop_0;
    logic       pop_1;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk_2f          (clk_2f),
        .reset_L         (reset_L),
        .fifo_empty_0    (fifo_empty_0),
        .fifo_data_0     (fifo_data_0),
        .fifo_empty_1    (fifo_empty_1),
        .fifo_data_1     (fifo_data_1),
        .out_almost_full (out_almost_full),
        .pop_0           (pop_0),
        .pop_1           (pop_1),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .state           (state)
    );

    always #5 clk_2f = ~clk_2f;

    // Inputs for the cycle, expected pops for those inputs, and the registered
    // outputs visible during the cycle (result of the previous edge).
    typedef struct {
        logic       rst;
        logic       e0;
        logic [7:0] d0;
        logic       e1;
        logic [7:0] d1;
        logic       af;
        logic       p0;
        logic       p1;
        logic       chk;
        logic [1:0] st;
        logic       v;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(logic rst, logic e0, logic [7:0] d0, logic e1, logic [7:0] d1,
                                logic af, logic p0, logic p1, logic chk, logic [1:0] st,
                                logic v, logic [7:0] dout);
        vec_t r;
        r.rst = rst; r.e0 = e0; r.d0 = d0; r.e1 = e1; r.d1 = d1; r.af = af;
        r.p0 = p0; r.p1 = p1; r.chk = chk; r.st = st; r.v = v; r.dout = dout;
        return r;
    endfunction

    task automatic check(string name, int idx, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, idx, got, want);
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        vecs[1]  = mk(1'b0, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        vecs[2]  = mk(1'b0, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        vecs[3]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        vecs[4]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00);
        vecs[5]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00);
        vecs[6]  = mk(1'b1, 1'b0, 8'h12, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 8'h11);
        vecs[7]  = mk(1'b1, 1'b0, 8'h13, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 8'h12);
        vecs[8]  = mk(1'b1, 1'b0, 8'h13, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h12);
        vecs[9]  = mk(1'b1, 1'b0, 8'h13, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h12);
        vecs[10] = mk(1'b1, 1'b0, 8'h13, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 8'h12);
        vecs[11] = mk(1'b1, 1'b0, 8'h14, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 8'h13);
        vecs[12] = mk(1'b1, 1'b0, 8'h14, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h14);
        vecs[13] = mk(1'b1, 1'b0, 8'h14, 1'b0, 8'h23, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h22);
        vecs[14] = mk(1'b1, 1'b0, 8'h14, 1'b0, 8'h24, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h23);
        vecs[15] = mk(1'b0, 1'b0, 8'h14, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 8'h24);
        vecs[16] = mk(1'b1, 1'b0, 8'h31, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        vecs[17] = mk(1'b1, 1'b0, 8'h31, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00);
        vecs[18] = mk(1'b1, 1'b0, 8'h31, 1'b0, 8'h24, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00);
        vecs[19] = mk(1'b1, 1'b1, 8'h31, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h31);
        vecs[20] = mk(1'b1, 1'b0, 8'h32, 1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h41);
        vecs[21] = mk(1'b1, 1'b0, 8'h32, 1'b0, 8'h43, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h42);
        vecs[22] = mk(1'b1, 1'b0, 8'h32, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h43);
        vecs[23] = mk(1'b1, 1'b0, 8'h33, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 8'h44);
        vecs[24] = mk(1'b1, 1'b1, 8'h33, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 8'h33);
        vecs[25] = mk(1'b1, 1'b1, 8'h33, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 8'hA5);
        vecs[26] = mk(1'b1, 1'b1, 8'h33, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'hA5);

        #1;
        for (int i = 0; i < 27; i++) begin
            reset_L         = vecs[i].rst;
            fifo_empty_0    = vecs[i].e0;
            fifo_data_0     = vecs[i].d0;
            fifo_empty_1    = vecs[i].e1;
            fifo_data_1     = vecs[i].d1;
            out_almost_full = vecs[i].af;
            #3;
            check("pops", i, {6'd0, pop_1, pop_0}, {6'd0, vecs[i].p1, vecs[i].p0});
            if (vecs[i].chk) begin
                check("state", i, {6'd0, state}, {6'd0, vecs[i].st});
                check("valid_out", i, {7'd0, valid_out}, {7'd0, vecs[i].v});
                check("data_out", i, data_out, vecs[i].dout);
            end
            @(posedge clk_2f);
            #1;
        end

        // Fresh reset, then continuous contention: grants 0,0,0,0,1,1,1,1,...
        reset_L         = 1'b0;
        fifo_empty_0    = 1'b0;
        fifo_empty_1    = 1'b0;
        out_almost_full = 1'b0;
        #3;
        check("rst_pops", 100, {6'd0, pop_1, pop_0}, 8'd0);
        @(posedge clk_2f);
        #1;
        reset_L = 1'b1;
        #3;
        check("rel_state", 101, {6'd0, state}, 8'd0);
        @(posedge clk_2f);
        #1;
        #3;
        check("init_state", 102, {6'd0, state}, 8'd1);
        check("init_pops", 102, {6'd0, pop_1, pop_0}, 8'd0);
        @(posedge clk_2f);
        #1;
        for (int k = 0; k < 16; k++) begin
            logic lane;
            logic [7:0] prev;
            lane        = ((k / 4) % 2) == 1;
            fifo_data_0 = 8'h50 + 8'(k);
            fifo_data_1 = 8'h60 + 8'(k);
            #3;
            check("burst_pops", 200 + k, {6'd0, pop_1, pop_0}, {6'd0, lane, ~lane});
            if (k > 0) begin
                prev = (((k - 1) / 4) % 2) == 1 ? 8'h60 + 8'(k - 1) : 8'h50 + 8'(k - 1);
                check("burst_valid", 200 + k, {7'd0, valid_out}, 8'd1);
                check("burst_data", 200 + k, data_out, prev);
            end
            @(posedge clk_2f);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
